// File: rtl/filter_pkt_rx.sv
// filter_pkt_rx: receive end of the filter-load packet protocol.
// It accepts FILTER_WRITE and FILTER_CLEAR packets addressed to MY_ADDR and
// unpacks up to two bytes per packet into a DEPTH-entry register file. A
// bitmap records which entries have been loaded.
// Optional feature macro FILTER_RX_ACK_EN: when it is defined, a completed
// bitmap raises a FILTER_ACK packet toward WMEM_ADDR before LOADED is reached.
// When it is undefined, a completed bitmap goes straight to LOADED and the
// outbound port is tied off.
//
// Handshake: a packet moves on a rising edge where in_valid && in_ready. The
// ACK moves on a rising edge where out_valid && out_ready. out_valid and
// out_packet are decoded from the registered state, so they stay stable until
// the ACK is accepted.
module filter_pkt_rx #(
  parameter int         DEPTH      = 25,
  parameter int         DATA_WIDTH = 8,
  parameter int         IDX_W      = 5,
  parameter logic [3:0] MY_ADDR    = 4'd1,
  parameter logic [3:0] WMEM_ADDR  = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32:0]           in_packet,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32:0]           out_packet,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  filter_loaded,
  output logic [7:0]            drop_count
);

  localparam logic [3:0]   OP_WRITE = 4'h1;
  localparam logic [3:0]   OP_CLEAR = 4'h2;
  localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, ACK, LOADED} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        bitmap, bitmap_next;

  logic                    accept;
  logic [3:0]              pkt_dest, pkt_op;
  logic [IDX_W-1:0]        pkt_start;
  logic [1:0]              pkt_cnt;
  logic [7:0]              pkt_byte1, pkt_byte0;
  logic [IDX_W:0]          idx0, idx1;
  logic                    we0, we1, drop;

  assign pkt_dest  = in_packet[32:29];
  assign pkt_op    = in_packet[28:25];
  assign pkt_start = in_packet[24:20];
  assign pkt_cnt   = in_packet[17:16];
  assign pkt_byte1 = in_packet[15:8];
  assign pkt_byte0 = in_packet[7:0];
  assign idx0      = {1'b0, pkt_start};
  assign idx1      = idx0 + 1'b1;

  // ACK holds off new packets. Reset also holds them off for its own cycle.
  assign in_ready = !rst && (state != ACK);
  assign accept   = in_valid && in_ready;

  // Decode the accepted packet into byte writes, a bitmap update, a drop flag and the next state
  always_comb begin
    state_next  = state;
    bitmap_next = bitmap;
    we0         = 1'b0;
    we1         = 1'b0;
    drop        = 1'b0;
    if (accept) begin
      if (pkt_dest != MY_ADDR) begin
        drop = 1'b1;
      end else if (pkt_op == OP_CLEAR) begin
        bitmap_next = '0;
        state_next  = IDLE;
      end else if (pkt_op == OP_WRITE && (pkt_cnt == 2'd1 || pkt_cnt == 2'd2)) begin
        we0  = (idx0 < DEPTH_W);
        we1  = (pkt_cnt == 2'd2) && (idx1 < DEPTH_W);
        // Any out-of-range byte counts the packet as dropped, but only once.
        drop = !we0 || ((pkt_cnt == 2'd2) && !we1);
        if (we0) bitmap_next[pkt_start] = 1'b1;
        if (we1) bitmap_next[idx1[IDX_W-1:0]] = 1'b1;
        if (state == LOADED) begin
          state_next = LOADED;
        end else if (&bitmap_next) begin
`ifdef FILTER_RX_ACK_EN
          state_next = ACK;
`else
          state_next = LOADED;
`endif
        end else begin
          state_next = LOAD;
        end
      end else begin
        drop = 1'b1;
      end
    end
`ifdef FILTER_RX_ACK_EN
    if (state == ACK && out_ready) state_next = LOADED;
`endif
  end

  // Decode the outputs from the registered state
`ifdef FILTER_RX_ACK_EN
  localparam logic [3:0] OP_ACK = 4'h3;
  always_comb begin
    filter_loaded = (state == LOADED);
    out_valid     = (state == ACK);
    out_packet    = (state == ACK) ? {WMEM_ADDR, OP_ACK, 25'(DEPTH)} : 33'd0;
  end
  logic unused_bits;
  assign unused_bits = ^in_packet[19:18];
`else
  always_comb begin
    filter_loaded = (state == LOADED);
    out_valid     = 1'b0;
    out_packet    = 33'd0;
  end
  logic unused_bits;
  assign unused_bits = ^{in_packet[19:18], out_ready, WMEM_ADDR};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Filter storage, loaded bitmap and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bitmap     <= '0;
      drop_count <= 8'd0;
    end else begin
      if (we0) mem[pkt_start]          <= DATA_WIDTH'(pkt_byte0);
      if (we1) mem[idx1[IDX_W-1:0]]    <= DATA_WIDTH'(pkt_byte1);
      bitmap <= bitmap_next;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Combinational read port. Indices at or beyond DEPTH read as zero.
  assign rd_data = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_filter_pkt_rx.sv
// Testbench for filter_pkt_rx. ACK packets are predicted into a queue when the
// completing write is issued. A monitor pops and compares them when the DUT
// offers an ACK that the bench is ready to take. Directed checks cover the
// register file, the counters and the status outputs.
module tb_filter_pkt_rx;

  localparam logic [3:0] MY  = 4'd1;
  localparam logic [32:0] ACK_PKT = {4'd0, 4'h3, 25'd25};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] in_packet = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:0] out_packet;
  logic [4:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        filter_loaded;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  filter_pkt_rx dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
    .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .filter_loaded(filter_loaded), .drop_count(drop_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: the ACK that is about to transfer must match the predicted one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 33'(out_valid), 33'd0);
      end else begin
        chk("ack_packet", out_packet, exp_q.pop_front());
      end
    end
  end

  function automatic logic [32:0] mk_wr(input logic [3:0] dest, input logic [3:0] op,
                                        input int start, input int cnt,
                                        input logic [7:0] b1, input logic [7:0] b0);
    logic [4:0] s;
    logic [1:0] c;
    s = 5'(start);
    c = 2'(cnt);
    return {dest, op, s, 2'b00, c, b1, b0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_in_reset", 33'(in_ready), 33'd0);
    rst = 1'b0;
  endtask

  // Drive one packet and return just after the edge that accepts it.
  task automatic send(input logic [32:0] p);
    int n;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_packet = p;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 33'(in_ready), 33'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Load all 25 entries with value index+1 (13 packets, the last one has count 1).
  task automatic full_load();
    for (int k = 0; k < 13; k++) begin
      int s;
      s = 2 * k;
`ifdef FILTER_RX_ACK_EN
      if (k == 12) exp_q.push_back(ACK_PKT);
`endif
      send(mk_wr(MY, 4'h1, s, (k == 12) ? 1 : 2, 8'(s + 2), 8'(s + 1)));
    end
  endtask

  task automatic chk_rd(input string name, input int a, input logic [7:0] exp);
    rd_addr = 5'(a);
    #1;
    chk(name, 33'(rd_data), 33'(exp));
  endtask

  // After full_load with out_ready high, check the ACK and the LOADED timing.
  task automatic chk_completion();
    @(negedge clk);
`ifdef FILTER_RX_ACK_EN
    chk("ack_out_valid", 33'(out_valid), 33'd1);
    chk("ack_in_ready", 33'(in_ready), 33'd0);
    chk("ack_not_loaded", 33'(filter_loaded), 33'd0);
    @(negedge clk);
`endif
    chk("loaded", 33'(filter_loaded), 33'd1);
    chk("loaded_out_valid", 33'(out_valid), 33'd0);
    chk("loaded_in_ready", 33'(in_ready), 33'd1);
  endtask

  initial begin
    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_out_packet", out_packet, 33'd0);
    chk("rst_filter_loaded", 33'(filter_loaded), 33'd0);
    chk("rst_drop_count", 33'(drop_count), 33'd0);
    chk_rd("rst_rd0", 0, 8'h00);
    chk_rd("rst_rd24", 24, 8'h00);

    // Address and opcode filtering
    send(mk_wr(4'd7, 4'h1, 0, 2, 8'h22, 8'h11));
    send(mk_wr(MY, 4'h5, 0, 2, 8'h22, 8'h11));
    send(mk_wr(MY, 4'h1, 0, 3, 8'h22, 8'h11));
    send(mk_wr(MY, 4'h1, 2, 0, 8'h44, 8'h33));
    @(negedge clk);
    chk("filt_drop_count", 33'(drop_count), 33'd4);
    chk_rd("filt_rd0", 0, 8'h00);
    chk_rd("filt_rd1", 1, 8'h00);
    chk_rd("filt_rd2", 2, 8'h00);
    chk("filt_not_loaded", 33'(filter_loaded), 33'd0);

    // Boundary index: byte0 lands at 24, byte1 at 25 is discarded
    do_reset();
    send(mk_wr(MY, 4'h1, 24, 2, 8'hBB, 8'hAA));
    @(negedge clk);
    chk_rd("bnd_rd24", 24, 8'hAA);
    chk_rd("bnd_rd25", 25, 8'h00);
    chk_rd("bnd_rd31", 31, 8'h00);
    chk("bnd_drop_count", 33'(drop_count), 33'd1);
    chk("bnd_not_loaded", 33'(filter_loaded), 33'd0);
    chk("bnd_in_ready", 33'(in_ready), 33'd1);

    // Full load with the ACK accepted at once
    do_reset();
    full_load();
    chk_completion();
    for (int i = 0; i < 25; i++) chk_rd($sformatf("full_rd%0d", i), i, 8'(i + 1));
    chk("full_drop_count", 33'(drop_count), 33'd0);

    // Rewrite while LOADED: the data changes, the state stays LOADED, no new ACK
    send(mk_wr(MY, 4'h1, 5, 1, 8'h00, 8'h5A));
    repeat (3) @(negedge clk);
    chk_rd("rewrite_rd5", 5, 8'h5A);
    chk("rewrite_loaded", 33'(filter_loaded), 33'd1);
    chk("rewrite_out_valid", 33'(out_valid), 33'd0);

    // Clear keeps the memory contents but empties the bitmap
    send({MY, 4'h2, 25'd0});
    @(negedge clk);
    chk("clr_loaded", 33'(filter_loaded), 33'd0);
    chk("clr_in_ready", 33'(in_ready), 33'd1);
    chk_rd("clr_rd3", 3, 8'h04);
    chk_rd("clr_rd5", 5, 8'h5A);

    // Partial reload after clear must not complete early
    send(mk_wr(MY, 4'h1, 0, 2, 8'h02, 8'h01));
    repeat (2) @(negedge clk);
    chk("clr_partial_not_loaded", 33'(filter_loaded), 33'd0);

    // Reload with the ACK held off for 5 cycles
`ifdef FILTER_RX_ACK_EN
    out_ready = 1'b0;
    full_load();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 33'(out_valid), 33'd1);
      chk("bp_out_packet", out_packet, ACK_PKT);
      chk("bp_in_ready", 33'(in_ready), 33'd0);
      chk("bp_not_loaded", 33'(filter_loaded), 33'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_not_loaded", 33'(filter_loaded), 33'd0);
    @(negedge clk);
    chk("bp_loaded", 33'(filter_loaded), 33'd1);
    chk("bp_out_valid_done", 33'(out_valid), 33'd0);
`else
    full_load();
    chk_completion();
`endif
    chk_rd("reload_rd5", 5, 8'h06);

    // Reset mid-load abandons everything
    do_reset();
    for (int k = 0; k < 5; k++) send(mk_wr(MY, 4'h1, 2 * k, 2, 8'(2 * k + 2), 8'(2 * k + 1)));
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 25; i++) chk_rd($sformatf("mid_rd%0d", i), i, 8'h00);
    chk("mid_not_loaded", 33'(filter_loaded), 33'd0);
    chk("mid_out_valid", 33'(out_valid), 33'd0);
    full_load();
    chk_completion();
    chk_rd("mid_reload_rd24", 24, 8'd25);

    // Drop counter saturates at 255
    do_reset();
    for (int k = 0; k < 260; k++) send(mk_wr(4'd9, 4'h1, 0, 1, 8'h00, 8'h01));
    @(negedge clk);
    chk("drop_saturate", 33'(drop_count), 33'd255);

    repeat (3) @(negedge clk);
    chk("ack_queue_empty", 33'(exp_q.size()), 33'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
